// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
//   Miss / fill / eviction sequencer for the 4-way, 32B-line L1 cache. It sits
//   beside the tag/data/valid/dirty/LRU arrays and drives their write strobes.
//   On a miss it picks a victim way and writes the victim back if it is dirty.
//   It then fetches the line, installs it and replays the stalled PE access,
//   which completes as an ordinary hit.
//
//   Optional feature macro: WRITE_ALLOCATE_EN
//     defined   : write misses allocate exactly like read misses
//     undefined : write misses are write-around (one mm_write, one stall cycle,
//                 no array/tag/LRU updates)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   pe_read, pe_write          stage-2 access qualifiers
//   pe_tag, pe_index           stage-2 request tag / set index
//   req_hit, req_miss          lookup result for the stage-2 access
//   val_out, mod_out, lru_out  valid / dirty / tree-PLRU bits of pe_index
//   tag_out                    four way tags, way w at [w*TAG_BITS +: TAG_BITS]
//   mm_readdata_valid          fill data from main memory valid this cycle
//   stall                      PE must hold its request stable
//   fsm_cc_*                   array write strobes and selects
//   mm_read, mm_write, mm_a    single-cycle main-memory commands + line address
// -----------------------------------------------------------------------------
module cache_miss_ctrl #(
  parameter int IDX_BITS = 13,
  parameter int TAG_BITS = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pe_read,
  input  logic                  pe_write,
  input  logic [TAG_BITS-1:0]   pe_tag,
  input  logic [IDX_BITS-1:0]   pe_index,
  input  logic                  req_hit,
  input  logic                  req_miss,
  input  logic [3:0]            val_out,
  input  logic [3:0]            mod_out,
  input  logic [2:0]            lru_out,
  input  logic [4*TAG_BITS-1:0] tag_out,
  input  logic                  mm_readdata_valid,
  output logic                  stall,
  output logic [3:0]            fsm_cc_way,
  output logic                  fsm_cc_fill,
  output logic                  fsm_cc_ary_write,
  output logic                  fsm_cc_tag_write,
  output logic                  fsm_cc_val_write,
  output logic                  fsm_cc_lru_write,
  output logic                  fsm_cc_mod_write,
  output logic                  fsm_cc_is_mod,
  output logic                  fsm_cc_readdata_valid,
  output logic                  mm_read,
  output logic                  mm_write,
  output logic [31:0]           mm_a
);

`ifdef WRITE_ALLOCATE_EN
  localparam logic LP_WRITE_ALLOC = 1'b1;
`else
  localparam logic LP_WRITE_ALLOC = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FILL    = 3'd4,
    S_REPLAY  = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_mm_read;
  logic                r_mm_write;
  logic [31:0]         r_mm_a;
  logic                r_fill;
  logic [3:0]          r_way;
  logic [3:0]          r_vic_oh;
  logic [TAG_BITS-1:0] r_tag;
  logic [IDX_BITS-1:0] r_idx;
  logic                r_wa_skip;   // write-around just issued; PE still shows that miss

  logic [1:0]          w_vic_idx;
  logic [3:0]          w_vic_oh;
  logic [TAG_BITS-1:0] w_vic_tag;
  logic                w_vic_dirty;
  logic                w_idle;
  logic                w_miss;
  logic                w_rd_hit;
  logic                w_wr_hit;
  logic                w_wr_around;

  // Victim choice: lowest invalid way, otherwise the tree-PLRU leaf
  always_comb begin
    w_vic_idx = 2'd0;
    if (!val_out[0]) begin
      w_vic_idx = 2'd0;
    end else if (!val_out[1]) begin
      w_vic_idx = 2'd1;
    end else if (!val_out[2]) begin
      w_vic_idx = 2'd2;
    end else if (!val_out[3]) begin
      w_vic_idx = 2'd3;
    end else if (!lru_out[0]) begin
      w_vic_idx = lru_out[1] ? 2'd1 : 2'd0;
    end else begin
      w_vic_idx = lru_out[2] ? 2'd3 : 2'd2;
    end
  end

  assign w_vic_oh    = 4'b0001 << w_vic_idx;
  assign w_vic_tag   = tag_out[w_vic_idx*TAG_BITS +: TAG_BITS];
  assign w_vic_dirty = val_out[w_vic_idx] & mod_out[w_vic_idx];

  // Hit/miss handling only happens in IDLE; reset forces every strobe low
  assign w_idle      = (r_state == S_IDLE) & ~r_wa_skip & ~reset;
  assign w_miss      = w_idle & req_miss & (pe_read | pe_write);
  assign w_rd_hit    = w_idle & req_hit & pe_read;
  assign w_wr_hit    = w_idle & req_hit & pe_write;
  assign w_wr_around = w_miss & pe_write & ~LP_WRITE_ALLOC;

  assign stall                 = w_miss | (r_state != S_IDLE);
  assign fsm_cc_way            = r_way;
  assign fsm_cc_fill           = r_fill;
  assign fsm_cc_tag_write      = r_fill;
  assign fsm_cc_val_write      = r_fill;
  assign fsm_cc_ary_write      = r_fill | w_wr_hit;
  assign fsm_cc_mod_write      = r_fill | w_wr_hit;
  assign fsm_cc_is_mod         = w_wr_hit;
  assign fsm_cc_lru_write      = w_rd_hit | w_wr_hit;
  assign fsm_cc_readdata_valid = w_rd_hit;
  assign mm_read               = r_mm_read;
  assign mm_write              = r_mm_write;
  assign mm_a                  = r_mm_a;

  // Miss sequencer: state, request latches and registered command outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mm_read  <= 1'b0;
      r_mm_write <= 1'b0;
      r_mm_a     <= 32'd0;
      r_fill     <= 1'b0;
      r_way      <= 4'd0;
      r_vic_oh   <= 4'd0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_wa_skip  <= 1'b0;
    end else begin
      // Commands and fill strobes are single-cycle pulses
      r_mm_read  <= 1'b0;
      r_mm_write <= 1'b0;
      r_fill     <= 1'b0;
      r_way      <= 4'd0;
      r_wa_skip  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wr_around) begin
            r_mm_write <= 1'b1;
            r_mm_a     <= {pe_tag, pe_index, 5'd0};
            r_wa_skip  <= 1'b1;
          end else if (w_miss) begin
            r_vic_oh <= w_vic_oh;
            r_tag    <= pe_tag;
            r_idx    <= pe_index;
            if (w_vic_dirty) begin
              r_state    <= S_WB;
              r_mm_write <= 1'b1;
              r_mm_a     <= {w_vic_tag, pe_index, 5'd0};
            end else begin
              r_state   <= S_RD_REQ;
              r_mm_read <= 1'b1;
              r_mm_a    <= {pe_tag, pe_index, 5'd0};
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WB: begin
          r_state   <= S_RD_REQ;
          r_mm_read <= 1'b1;
          r_mm_a    <= {r_tag, r_idx, 5'd0};
        end
        S_RD_REQ, S_RD_WAIT: begin
          // Fill data may already arrive in the cycle mm_read is issued
          if (mm_readdata_valid) begin
            r_state <= S_FILL;
            r_fill  <= 1'b1;
            r_way   <= r_vic_oh;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_FILL: begin
          r_state <= S_REPLAY;
        end
        S_REPLAY: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl. A per-cycle expectation schedule is
// built from the miss/hit timing rules; one compare process checks every cycle.
module tb_cache_miss_ctrl;
  localparam int IB = 13;
  localparam int TB = 14;
  localparam int NCYC = 400;

  logic clk = 1'b0;
  logic reset;
  logic pe_read, pe_write;
  logic [TB-1:0] pe_tag;
  logic [IB-1:0] pe_index;
  logic req_hit, req_miss;
  logic [3:0] val_out, mod_out;
  logic [2:0] lru_out;
  logic [4*TB-1:0] tag_out;
  logic mm_readdata_valid;
  logic stall, fsm_cc_fill, fsm_cc_ary_write, fsm_cc_tag_write, fsm_cc_val_write;
  logic fsm_cc_lru_write, fsm_cc_mod_write, fsm_cc_is_mod, fsm_cc_readdata_valid;
  logic mm_read, mm_write;
  logic [3:0] fsm_cc_way;
  logic [31:0] mm_a;

  cache_miss_ctrl #(.IDX_BITS(IB), .TAG_BITS(TB)) dut (
    .clk(clk), .reset(reset), .pe_read(pe_read), .pe_write(pe_write),
    .pe_tag(pe_tag), .pe_index(pe_index), .req_hit(req_hit), .req_miss(req_miss),
    .val_out(val_out), .mod_out(mod_out), .lru_out(lru_out), .tag_out(tag_out),
    .mm_readdata_valid(mm_readdata_valid), .stall(stall), .fsm_cc_way(fsm_cc_way),
    .fsm_cc_fill(fsm_cc_fill), .fsm_cc_ary_write(fsm_cc_ary_write),
    .fsm_cc_tag_write(fsm_cc_tag_write), .fsm_cc_val_write(fsm_cc_val_write),
    .fsm_cc_lru_write(fsm_cc_lru_write), .fsm_cc_mod_write(fsm_cc_mod_write),
    .fsm_cc_is_mod(fsm_cc_is_mod), .fsm_cc_readdata_valid(fsm_cc_readdata_valid),
    .mm_read(mm_read), .mm_write(mm_write), .mm_a(mm_a)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector per cycle:
  // [14] stall [13:10] way [9] fill [8] ary [7] tag [6] val [5] lru
  // [4] mod_write [3] is_mod [2] readdata_valid [1] mm_read [0] mm_write
  logic [14:0] exp_v [NCYC];
  logic [31:0] exp_a [NCYC];
  logic [14:0] act_v, want_v;
  bit chk_en = 1'b0;
  int n_chk = 0, n_pass = 0;
  int c_stall, c_rd, c_wr, c_tagw;
  logic [31:0] last_rd_a, last_wr_a;
  logic [3:0] last_fill_way;

  // Per-cycle comparison of every output against the schedule
  always @(negedge clk) begin
    if (chk_en) begin
      act_v = {stall, fsm_cc_way, fsm_cc_fill, fsm_cc_ary_write, fsm_cc_tag_write,
               fsm_cc_val_write, fsm_cc_lru_write, fsm_cc_mod_write, fsm_cc_is_mod,
               fsm_cc_readdata_valid, mm_read, mm_write};
      n_chk++;
      if (cyc >= NCYC) begin
        $display("FAIL cycle_budget: cycle %0d beyond schedule of %0d", cyc, NCYC);
      end else begin
        want_v = exp_v[cyc];
        if (act_v !== want_v || ((want_v[1] | want_v[0]) && mm_a !== exp_a[cyc]))
          $display("FAIL outputs cyc%0d: got %b a=%h, want %b a=%h",
                   cyc, act_v, mm_a, want_v, exp_a[cyc]);
        else
          n_pass++;
      end
      c_stall += int'(stall);
      c_rd    += int'(mm_read);
      c_wr    += int'(mm_write);
      c_tagw  += int'(fsm_cc_tag_write);
      if (mm_read)     last_rd_a = mm_a;
      if (mm_write)    last_wr_a = mm_a;
      if (fsm_cc_fill) last_fill_way = fsm_cc_way;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic clr_cnt();
    c_stall = 0; c_rd = 0; c_wr = 0; c_tagw = 0;
    last_rd_a = 32'd0; last_wr_a = 32'd0; last_fill_way = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pe_read = 1'b0; pe_write = 1'b0; req_hit = 1'b0; req_miss = 1'b0;
    mm_readdata_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    idle_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Replacement rule: lowest invalid way, else PLRU leaf
  function automatic int pick_victim(input logic [3:0] v, input logic [2:0] l);
    for (int w = 0; w < 4; w++) if (!v[w]) return w;
    if (!l[0]) return l[1] ? 1 : 0;
    return l[2] ? 3 : 2;
  endfunction

  task automatic plan_hit(input int t, input logic wr);
    if (wr) begin
      exp_v[t][8] = 1'b1; exp_v[t][4] = 1'b1; exp_v[t][3] = 1'b1; exp_v[t][5] = 1'b1;
    end else begin
      exp_v[t][5] = 1'b1; exp_v[t][2] = 1'b1;
    end
  endtask

  task automatic do_hit(input logic wr, input logic [TB-1:0] tg, input logic [IB-1:0] ix);
    plan_hit(cyc, wr);
    pe_read = ~wr; pe_write = wr; pe_tag = tg; pe_index = ix;
    req_hit = 1'b1; req_miss = 1'b0; mm_readdata_valid = 1'b0;
    tick();
  endtask

  // Allocating miss: optional writeback, read, fill after lat cycles, replay, hit
  task automatic do_miss(input logic wr, input logic [TB-1:0] tg, input logic [IB-1:0] ix,
                         input logic [3:0] v, input logic [3:0] m, input logic [2:0] l,
                         input logic [4*TB-1:0] tags, input int lat);
    int t, vw, r, f;
    logic dirty;
    t = cyc;
    vw = pick_victim(v, l);
    dirty = v[vw] & m[vw];
    r = dirty ? t + 2 : t + 1;
    f = r + lat + 1;
    for (int k = t; k <= f + 1; k++) exp_v[k][14] = 1'b1;
    if (dirty) begin
      exp_v[t+1][0] = 1'b1;
      exp_a[t+1] = {tags[vw*TB +: TB], ix, 5'd0};
    end
    exp_v[r][1] = 1'b1;
    exp_a[r] = {tg, ix, 5'd0};
    exp_v[f][13:10] = 4'(4'b0001 << vw);
    exp_v[f][9] = 1'b1; exp_v[f][8] = 1'b1; exp_v[f][7] = 1'b1;
    exp_v[f][6] = 1'b1; exp_v[f][4] = 1'b1;
    for (int k = t; k <= f + 1; k++) begin
      pe_read = ~wr; pe_write = wr; pe_tag = tg; pe_index = ix;
      req_miss = 1'b1; req_hit = 1'b0;
      val_out = v; mod_out = m; lru_out = l; tag_out = tags;
      mm_readdata_valid = (k == r + lat);
      tick();
    end
    do_hit(wr, tg, ix);
    idle(1);
  endtask

  // Write-around miss: stall in the detect cycle, one mm_write the cycle after
  task automatic do_write_around(input logic [TB-1:0] tg, input logic [IB-1:0] ix);
    int t;
    t = cyc;
    exp_v[t][14] = 1'b1;
    exp_v[t+1][0] = 1'b1;
    exp_a[t+1] = {tg, ix, 5'd0};
    for (int k = 0; k < 2; k++) begin
      pe_read = 1'b0; pe_write = 1'b1; pe_tag = tg; pe_index = ix;
      req_miss = 1'b1; req_hit = 1'b0; val_out = 4'hF; mod_out = 4'h0;
      lru_out = 3'b000; mm_readdata_valid = 1'b0;
      tick();
    end
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_v[i] = 15'd0;
      exp_a[i] = 32'd0;
    end
    idle_in();
    pe_tag = '0; pe_index = '0; val_out = 4'd0; mod_out = 4'd0; lru_out = 3'd0;
    tag_out = '0;
    clr_cnt();
    reset = 1'b1;
    chk_en = 1'b1;
    tick(); tick(); tick();
    check("reset_mm_a", mm_a, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Clean read miss to 0x0004_0020, all ways invalid, fill after 2 cycles
    clr_cnt();
    do_miss(1'b0, 14'd1, 13'd1, 4'b0000, 4'b0000, 3'b000, '0, 2);
    check("rd_miss_addr", last_rd_a, 32'h0004_0020);
    check("rd_miss_fill_way", {28'd0, last_fill_way}, 32'h1);
    check("rd_miss_reads", c_rd, 32'd1);
    check("rd_miss_writes", c_wr, 32'd0);

    // Dirty miss: all valid, way2 dirty, lru=001 picks way2
    clr_cnt();
    do_miss(1'b0, 14'h0155, 13'h01F0, 4'hF, 4'b0100, 3'b001,
            {14'h0033, 14'h2ABC, 14'h0022, 14'h0011}, 1);
    check("dirty_wb_addr", last_wr_a, {14'h2ABC, 13'h01F0, 5'h00});
    check("dirty_rd_addr", last_rd_a, {14'h0155, 13'h01F0, 5'h00});
    check("dirty_fill_way", {28'd0, last_fill_way}, 32'h4);
    check("dirty_writes", c_wr, 32'd1);

    // Hits: write then read, no stall
    clr_cnt();
    do_hit(1'b1, 14'h0155, 13'h01F0);
    do_hit(1'b0, 14'h0001, 13'h0001);
    idle(1);
    check("hit_stall", c_stall, 32'd0);

    // Fill data in the RD_REQ cycle: four stall cycles, way3 the only invalid
    clr_cnt();
    do_miss(1'b0, 14'h3FFF, 13'h1FFF, 4'b0111, 4'b0111, 3'b000, '0, 0);
    check("fast_miss_stall", c_stall, 32'd4);
    check("fast_miss_way", {28'd0, last_fill_way}, 32'h8);

    // All valid, clean, lru=110 -> way1; lru=101 -> way3
    clr_cnt();
    do_miss(1'b0, 14'h0A0A, 13'h0055, 4'hF, 4'h0, 3'b110, '0, 3);
    check("plru_way1", {28'd0, last_fill_way}, 32'h2);
    clr_cnt();
    do_miss(1'b0, 14'h0B0B, 13'h0066, 4'hF, 4'h0, 3'b101, '0, 1);
    check("plru_way3", {28'd0, last_fill_way}, 32'h8);

    // Write miss
    clr_cnt();
`ifdef WRITE_ALLOCATE_EN
    do_miss(1'b1, 14'h1234, 13'h0ABC, 4'b0000, 4'b0000, 3'b000, '0, 1);
    check("wmiss_reads", c_rd, 32'd1);
`else
    do_write_around(14'h1234, 13'h0ABC);
    check("wmiss_reads", c_rd, 32'd0);
    check("wmiss_writes", c_wr, 32'd1);
    check("wmiss_tag_writes", c_tagw, 32'd0);
    check("wmiss_stall", c_stall, 32'd1);
    check("wmiss_addr", last_wr_a, {14'h1234, 13'h0ABC, 5'h00});
`endif

    // Reset in RD_WAIT, then a late fill response that must be ignored
    clr_cnt();
    begin
      int t;
      t = cyc;
      exp_v[t][14] = 1'b1;
      exp_v[t+1][14] = 1'b1; exp_v[t+1][1] = 1'b1; exp_a[t+1] = {14'd5, 13'd7, 5'd0};
      exp_v[t+2][14] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        pe_read = 1'b1; pe_write = 1'b0; pe_tag = 14'd5; pe_index = 13'd7;
        req_miss = 1'b1; req_hit = 1'b0; val_out = 4'd0; mod_out = 4'd0;
        mm_readdata_valid = 1'b0;
        tick();
      end
      idle_in();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      mm_readdata_valid = 1'b1;
      tick();
      idle(3);
    end
    check("rst_rdwait_tagw", c_tagw, 32'd0);
    check("rst_rdwait_stall", c_stall, 32'd3);
    check("rst_rdwait_stall_now", {31'd0, stall}, 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Miss/fill/eviction sequencer for the 1MB 4-way, 32B-line L1 cache. It sits beside the tag/data/valid/dirty/LRU arrays and drives their write strobes. It picks a victim way, writes back dirty victims, fetches the line from main memory and installs it. It then replays the stalled PE access so it completes as a hit.

## Interface
- IDX_BITS, 13, set index width (a[17:5])
- TAG_BITS, 14, tag width (a[31:18])
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pe_read, pe_write  in  1 each  registered (stage-2) access qualifiers
- pe_tag  in  TAG_BITS  registered request tag
- pe_index  in  IDX_BITS  registered request index
- req_hit, req_miss  in  1 each  lookup result of current stage-2 access
- val_out, mod_out  in  4 each  per-way valid/dirty bits of pe_index
- lru_out  in  3  tree-PLRU bits of pe_index
- tag_out  in  4*TAG_BITS  way tags; way w at [w*TAG_BITS +: TAG_BITS]
- mm_readdata_valid  in  1  fill data (mm_rd) valid this cycle
- stall  out  1  PE must hold a/be/read/write/wd stable
- fsm_cc_way  out  4  one-hot way for fill/tag/valid/dirty writes
- fsm_cc_fill  out  1  select mm_rd, full byte enables, onto data array
- fsm_cc_ary_write, fsm_cc_tag_write, fsm_cc_val_write  out  1 each  array strobes
- fsm_cc_lru_write  out  1  update PLRU toward accessed way
- fsm_cc_mod_write, fsm_cc_is_mod  out  1 each  dirty bit strobe/value
- fsm_cc_readdata_valid  out  1  read hit data valid
- mm_read, mm_write  out  1 each  single-cycle main-memory commands
- mm_a  out  32  line-aligned main-memory address (bits [4:0]=0)

## Operation
- States: IDLE, WB, RD_REQ, RD_WAIT, FILL, REPLAY. State encoding is internal.
- IDLE, read hit: fsm_cc_lru_write=1, fsm_cc_readdata_valid=1 (combinational).
- IDLE, write hit: fsm_cc_ary_write=1, fsm_cc_mod_write=1, fsm_cc_is_mod=1, fsm_cc_lru_write=1.
- IDLE, req_miss: latch victim way, victim tag, pe_tag and pe_index. Go to WB if the victim is valid and dirty, else RD_REQ. Assert stall.
- Victim selection:
  - lowest-numbered invalid way.
  - If all four ways are valid: lru[0]=0 -> lru[1] ? way1 : way0; lru[0]=1 -> lru[2] ? way3 : way2.
- WB (1 cycle): mm_write=1, mm_a={victim_tag, index, 5'b0} -> RD_REQ.
- RD_REQ (1 cycle): mm_read=1, mm_a={pe_tag, index, 5'b0} -> RD_WAIT. If mm_readdata_valid is high this cycle, go to FILL instead.
- RD_WAIT: hold until mm_readdata_valid -> FILL. There is no timeout.
- FILL (1 cycle), fsm_cc_way=victim:
  - fsm_cc_fill=1, fsm_cc_ary_write=1, fsm_cc_tag_write=1, fsm_cc_val_write=1
  - fsm_cc_mod_write=1, fsm_cc_is_mod=0
  - -> REPLAY
- REPLAY (1 cycle): the PE access is re-looked-up. The next IDLE cycle sees req_hit and performs the normal hit action, then stall drops.
- stall is high in WB, RD_REQ, RD_WAIT, FILL and REPLAY, and in the IDLE cycle that detects the miss.
- mm_readdata_valid outside RD_REQ/RD_WAIT is ignored.
- Reset at any time:
  - state -> IDLE and latches cleared.
  - A fill response arriving after reset is ignored.

## Timing
- Reset values: all outputs 0, mm_a=0, state IDLE.
- Hit: 0 added cycles; strobes are valid in the same cycle as req_hit.
- Clean miss detected in cycle T:
  - RD_REQ at T+1.
  - Fill data at T+1+L (L≥0 cycles after mm_read).
  - FILL in the following cycle, REPLAY next, hit completes in the cycle after REPLAY.
- Dirty miss: one extra cycle (WB) before RD_REQ.
- mm_read and mm_write are never high in the same cycle; each is exactly 1 cycle per miss.

## Configuration
- WRITE_ALLOCATE_EN defined: write misses allocate exactly like read misses.
- WRITE_ALLOCATE_EN undefined: a write miss is write-around.
  - One-cycle mm_write with mm_a={pe_tag, index, 5'b0}.
  - Stall for that single cycle; no fill, and no array, tag or LRU updates.
  - Read misses are unchanged.

## Test plan
- Reset mid-RD_WAIT, then mm_readdata_valid pulse -> state IDLE, stall=0, no FILL strobes.
- Read miss to 0x0004_0020, index 1, all ways invalid:
  - mm_read one cycle with mm_a=0x0004_0020, no mm_write.
  - After valid: FILL with fsm_cc_way=4'b0001.
  - Then read hit with fsm_cc_readdata_valid=1.
- Read miss with all ways valid, way2 dirty, lru=3'b001:
  - victim way2; mm_write with mm_a={tag2, index, 5'b0}, then mm_read next cycle.
  - fsm_cc_is_mod=0 at FILL.
- Write hit on way3 -> same cycle: ary_write=1, mod_write=1, is_mod=1, lru_write=1; stall=0.
- mm_readdata_valid in the RD_REQ cycle -> FILL in the next cycle; total clean miss = 4 cycles.
- Write miss without WRITE_ALLOCATE_EN -> a single mm_write and no mm_read; fsm_cc_tag_write never asserted.
